// File: rtl/if_stage_fetch_buffer.sv
// Instruction-fetch stage: req/addr_ok/data_ok fetch with a credit-limited number of
// in-flight requests, an in-order instruction FIFO toward ID, and redirect cancellation.

module if_stage_fetch_buffer_chk #(
  parameter int OCW = 2
) (
  input logic           clk,
  input logic           resetn,
  input logic           data_ok_i,
  input logic [OCW-1:0] out_cnt_i
);
  // A response may only return for a request that is still in flight.
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!resetn)
    data_ok_i |-> (out_cnt_i != {OCW{1'b0}}));
endmodule

module if_stage_fetch_buffer #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_allowin,
  output logic        if_to_id_valid,
  output logic [31:0] if_to_id_pc,
  output logic [31:0] if_to_id_inst
);
  localparam int FPW = $clog2(FIFO_DEPTH);
  localparam int FCW = FPW + 1;
  localparam int QPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [OCW-1:0] out_cnt_q, out_cnt_d;
  logic [OCW-1:0] cancel_cnt_q, cancel_cnt_d;
  logic [31:0]    pend_pc_q [MAX_OUTSTANDING];
  logic [QPW-1:0] pend_wp_q, pend_wp_d, pend_rp_q, pend_rp_d;
  logic [31:0]    fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]    fifo_inst_q [FIFO_DEPTH];
  logic [FPW-1:0] fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
  logic [FCW-1:0] fifo_cnt_q, fifo_cnt_d;

  logic [31:0] credit_s;
  logic        req_s, accept_s, discard_s, fifo_push_s, fifo_pop_s;

  function automatic logic [QPW-1:0] pend_inc(input logic [QPW-1:0] p);
    pend_inc = (p == QPW'(MAX_OUTSTANDING - 1)) ? {QPW{1'b0}} : p + QPW'(1);
  endfunction

  // Credit check: every live in-flight request must already own a FIFO slot.
  always_comb begin
    credit_s    = 32'(fifo_cnt_q) + 32'(out_cnt_q) - 32'(cancel_cnt_q);
    req_s       = resetn && !br_taken && (out_cnt_q < OCW'(MAX_OUTSTANDING)) &&
                  (credit_s < 32'(FIFO_DEPTH));
    accept_s    = req_s && inst_sram_addr_ok;
    discard_s   = inst_sram_data_ok && (cancel_cnt_q != {OCW{1'b0}});
    fifo_push_s = inst_sram_data_ok && !discard_s && !br_taken;
    fifo_pop_s  = if_to_id_valid && id_allowin && !br_taken;
  end

  // Next-state for PC, counters and queue pointers; redirect overrides everything.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    out_cnt_d    = out_cnt_q;
    cancel_cnt_d = cancel_cnt_q;
    pend_wp_d    = pend_wp_q;
    pend_rp_d    = pend_rp_q;
    fifo_wp_d    = fifo_wp_q;
    fifo_rp_d    = fifo_rp_q;
    fifo_cnt_d   = fifo_cnt_q;

    if (br_taken) fetch_pc_d = br_target;
    else if (accept_s) fetch_pc_d = fetch_pc_q + 32'd4;
    else fetch_pc_d = fetch_pc_q;

    case ({accept_s, inst_sram_data_ok})
      2'b10:   out_cnt_d = out_cnt_q + OCW'(1);
      2'b01:   out_cnt_d = out_cnt_q - OCW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase

    // Everything still in flight after this cycle belongs to the old path.
    if (br_taken) cancel_cnt_d = out_cnt_q - OCW'(inst_sram_data_ok);
    else if (discard_s) cancel_cnt_d = cancel_cnt_q - OCW'(1);
    else cancel_cnt_d = cancel_cnt_q;

    pend_wp_d = accept_s ? pend_inc(pend_wp_q) : pend_wp_q;
    pend_rp_d = inst_sram_data_ok ? pend_inc(pend_rp_q) : pend_rp_q;

    if (br_taken) begin
      fifo_wp_d  = {FPW{1'b0}};
      fifo_rp_d  = {FPW{1'b0}};
      fifo_cnt_d = {FCW{1'b0}};
    end else begin
      fifo_wp_d  = fifo_wp_q + FPW'(fifo_push_s);
      fifo_rp_d  = fifo_rp_q + FPW'(fifo_pop_s);
      fifo_cnt_d = fifo_cnt_q + FCW'(fifo_push_s) - FCW'(fifo_pop_s);
    end
  end

  // State registers and storage arrays.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q   <= RESET_PC;
      out_cnt_q    <= {OCW{1'b0}};
      cancel_cnt_q <= {OCW{1'b0}};
      pend_wp_q    <= {QPW{1'b0}};
      pend_rp_q    <= {QPW{1'b0}};
      fifo_wp_q    <= {FPW{1'b0}};
      fifo_rp_q    <= {FPW{1'b0}};
      fifo_cnt_q   <= {FCW{1'b0}};
      for (int i = 0; i < MAX_OUTSTANDING; i++) pend_pc_q[i] <= 32'h0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]   <= 32'h0;
        fifo_inst_q[i] <= 32'h0;
      end
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      out_cnt_q    <= out_cnt_d;
      cancel_cnt_q <= cancel_cnt_d;
      pend_wp_q    <= pend_wp_d;
      pend_rp_q    <= pend_rp_d;
      fifo_wp_q    <= fifo_wp_d;
      fifo_rp_q    <= fifo_rp_d;
      fifo_cnt_q   <= fifo_cnt_d;
      if (accept_s) pend_pc_q[pend_wp_q] <= fetch_pc_q;
      if (fifo_push_s) begin
        fifo_pc_q[fifo_wp_q]   <= pend_pc_q[pend_rp_q];
        fifo_inst_q[fifo_wp_q] <= inst_sram_rdata;
      end
    end
  end

  assign inst_sram_req   = req_s;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_addr  = fetch_pc_q;
  assign inst_sram_wdata = 32'h0;

  assign if_to_id_valid = (fifo_cnt_q != {FCW{1'b0}});
  assign if_to_id_pc    = fifo_pc_q[fifo_rp_q];
  assign if_to_id_inst  = fifo_inst_q[fifo_rp_q];

  if_stage_fetch_buffer_chk #(.OCW(OCW)) u_chk (
    .clk       (clk),
    .resetn    (resetn),
    .data_ok_i (inst_sram_data_ok),
    .out_cnt_i (out_cnt_q)
  );
endmodule

// File: tb/tb_if_stage_fetch_buffer.sv
// Scoreboard bench for if_stage_fetch_buffer: a memory model answers fetches with inst = ~pc,
// stimulus pushes hand-derived expected PCs, and a monitor checks every ID handoff.

module tb_if_stage_fetch_buffer;
  logic        clk, resetn;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata, rdata;
  logic        addr_ok, data_ok;
  logic        br_taken, id_allowin, valid;
  logic [31:0] br_target, id_pc, id_inst;

  int cyc = 0;
  int allow = 0;
  int lat = 1;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  int          dlv_cyc[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_inst[$];

  if_stage_fetch_buffer dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
    .inst_sram_wstrb(wstrb), .inst_sram_addr(addr), .inst_sram_wdata(wdata),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(rdata),
    .br_taken(br_taken), .br_target(br_target), .id_allowin(id_allowin),
    .if_to_id_valid(valid), .if_to_id_pc(id_pc), .if_to_id_inst(id_inst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_pc.push_back(pc);
    exp_inst.push_back(~pc);
  endtask

  // Memory model: in-order responses lat cycles after accept; accepts limited by allow.
  initial begin
    addr_ok = 1'b0;
    data_ok = 1'b0;
    rdata   = 32'h0;
    forever begin
      @(posedge clk); #2;
      if (!resetn) begin
        mq_addr.delete(); mq_due.delete(); acc_addr.delete(); acc_cyc.delete();
        data_ok = 1'b0;
      end else if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
        data_ok = 1'b1;
        rdata   = ~mq_addr.pop_front();
        void'(mq_due.pop_front());
      end else begin
        data_ok = 1'b0;
      end
      addr_ok = (acc_addr.size() < allow);
      @(negedge clk);
      if (resetn && req && addr_ok) begin
        mq_addr.push_back(addr);
        mq_due.push_back(cyc + lat);
        acc_addr.push_back(addr);
        acc_cyc.push_back(cyc);
      end
    end
  end

  // Monitor: every instruction ID accepts must match the scoreboard head.
  initial begin
    logic [31:0] e_pc, e_inst;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        dlv_cyc.delete();
      end else if (valid && id_allowin && !br_taken) begin
        if (exp_pc.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got pc %h, expected no instruction", id_pc);
        end else begin
          e_pc   = exp_pc.pop_front();
          e_inst = exp_inst.pop_front();
          check("id_pc", id_pc, e_pc);
          check("id_inst", id_inst, e_inst);
          dlv_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic do_reset();
    resetn   = 1'b0;
    br_taken = 1'b0;
    allow    = 0;
    exp_pc.delete();
    exp_inst.delete();
    #1;
    check("rst_req", 32'(req), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_pc", id_pc, 32'h0);
    check("rst_inst", id_inst, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_pc.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check(name, 32'(exp_pc.size()), 32'h0);
  endtask

  task automatic wait_acc(input int n);
    int t = 0;
    while (acc_addr.size() < n && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("wait_acc", 32'(acc_addr.size() >= n), 32'h1);
  endtask

  initial begin
    resetn = 1'b0; br_taken = 1'b0; br_target = 32'h0; id_allowin = 1'b0;
    do_reset();
    check("const_wr", 32'(wr), 32'h0);
    check("const_size", 32'(size), 32'h2);
    check("const_wstrb", 32'(wstrb), 32'h0);
    check("const_wdata", wdata, 32'h0);

    // T1: zero-wait stream; with a 2-deep FIFO the credit rule stalls the third request one cycle.
    allow = 3; lat = 1; id_allowin = 1'b1;
    push_exp(32'h1c000000); push_exp(32'h1c000004); push_exp(32'h1c000008);
    wait_drain("t1_drain");
    check("t1_acc_n", 32'(acc_addr.size()), 32'd3);
    if (acc_addr.size() == 3 && dlv_cyc.size() == 3) begin
      check("t1_addr1", acc_addr[1], 32'h1c000004);
      check("t1_addr2", acc_addr[2], 32'h1c000008);
      check("t1_acc_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
      check("t1_acc_gap2", 32'(acc_cyc[2] - acc_cyc[0]), 32'd3);
      check("t1_first_lat", 32'(dlv_cyc[0] - acc_cyc[0]), 32'd2);
      check("t1_dlv_gap1", 32'(dlv_cyc[1] - dlv_cyc[0]), 32'd1);
      check("t1_dlv_gap2", 32'(dlv_cyc[2] - dlv_cyc[0]), 32'd3);
    end

    // T2: ID stalled, FIFO fills and req drops; release drains in order, fetch resumes at +8.
    do_reset();
    allow = 3; lat = 1; id_allowin = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check("t2_req_low", 32'(req), 32'h0);
    check("t2_valid", 32'(valid), 32'h1);
    check("t2_head_pc", id_pc, 32'h1c000000);
    check("t2_acc_n", 32'(acc_addr.size()), 32'd2);
    push_exp(32'h1c000000); push_exp(32'h1c000004); push_exp(32'h1c000008);
    id_allowin = 1'b1;
    wait_drain("t2_drain");
    if (acc_addr.size() == 3) check("t2_resume_addr", acc_addr[2], 32'h1c000008);

    // T3: redirect with two slow requests in flight; both late responses are discarded.
    do_reset();
    allow = 2; lat = 4; id_allowin = 1'b1;
    wait_acc(2);
    br_taken = 1'b1; br_target = 32'h1c000100;
    @(posedge clk); #1;
    br_taken = 1'b0;
    allow = 4; lat = 1;
    push_exp(32'h1c000100); push_exp(32'h1c000104);
    wait_drain("t3_drain");
    if (acc_addr.size() == 4) begin
      check("t3_new_addr0", acc_addr[2], 32'h1c000100);
      check("t3_new_addr1", acc_addr[3], 32'h1c000104);
    end

    // T4: redirect in the same cycle as a response and a head pop.
    do_reset();
    allow = 3; lat = 1; id_allowin = 1'b1;
    push_exp(32'h1c000200);
    repeat (2) begin @(posedge clk); #1; end
    br_taken = 1'b1; br_target = 32'h1c000200;
    #3;
    check("t4_head_valid", 32'(valid), 32'h1);
    check("t4_head_pc", id_pc, 32'h1c000000);
    check("t4_data_ok", 32'(data_ok), 32'h1);
    @(posedge clk); #1;
    br_taken = 1'b0;
    #3;
    check("t4_flushed", 32'(valid), 32'h0);
    check("t4_req", 32'(req), 32'h1);
    check("t4_addr", addr, 32'h1c000200);
    wait_drain("t4_drain");

    // T5: addr_ok withheld; req and addr hold steady and nothing enters the FIFO.
    do_reset();
    allow = 0; id_allowin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #3;
      check("t5_req", 32'(req), 32'h1);
      check("t5_addr", addr, 32'h1c000000);
      check("t5_valid", 32'(valid), 32'h0);
      @(posedge clk); #1;
    end
    allow = 1;
    push_exp(32'h1c000000);
    wait_drain("t5_drain");
    check("t5_acc_n", 32'(acc_addr.size()), 32'd1);

    // T6: reset while the FIFO holds an entry and a request is in flight.
    do_reset();
    allow = 2; lat = 4; id_allowin = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("t6_pre_valid", 32'(valid), 32'h1);
    do_reset();
    allow = 1; lat = 1; id_allowin = 1'b1;
    push_exp(32'h1c000000);
    wait_drain("t6_drain");
    if (acc_addr.size() != 0) check("t6_restart_addr", acc_addr[0], 32'h1c000000);
    check("t6_acc_n", 32'(acc_addr.size()), 32'd1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
